// File: rtl/mux_tree_sequencer.sv
// Issue stage for the mux tree: buffers {sel,a,b,c} operands in a small FIFO,
// drives one transaction at a time onto the tree and returns y over valid/ready.
module mux_tree_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sel,
    input  logic                     in_a,
    input  logic                     in_b,
    input  logic                     in_c,
    output logic                     mt_sel,
    output logic                     mt_a,
    output logic                     mt_b,
    output logic                     mt_c,
    input  logic                     mt_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_y,
    output logic                     out_sel,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         done_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Entry layout is {sel, a, b, c}
    logic [3:0]       mem [DEPTH];
    logic [3:0]       head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    state_t           state_q, state_d;
    logic [3:0]       mt_q, mt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_y_q, out_y_d;
    logic             out_sel_q, out_sel_d;
    logic [CNT_W-1:0] done_q, done_d;

    logic             full;
    logic             push;
    logic             pop;

    // in_ready depends only on registered occupancy, so a same-cycle pop never frees a slot
    assign full = (level_q == LVL_W'(DEPTH));
    assign push = in_valid && !full;
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_sel, in_a, in_b, in_c};
        end
    end

    always_comb begin
        state_d     = state_q;
        mt_d        = mt_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_sel_d   = out_sel_q;
        done_d      = done_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                out_y_d     = mt_y;
                out_sel_d   = mt_q[3];
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    done_d      = done_q + CNT_W'(1);
                    out_valid_d = 1'b0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            mt_d = head;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= IDLE;
            mt_q        <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_sel_q   <= 1'b0;
            done_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            mt_q        <= mt_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_sel_q   <= out_sel_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = !full;
    assign mt_sel     = mt_q[3];
    assign mt_a       = mt_q[2];
    assign mt_b       = mt_q[1];
    assign mt_c       = mt_q[0];
    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_sel    = out_sel_q;
    assign fifo_level = level_q;
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_mux_tree_sequencer.sv
// Bench for mux_tree_sequencer: directed scenarios with literal expectations plus
// random traffic checked every cycle against a queue-based behavioural model.
module tb_mux_tree_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   in_sel = 1'b0;
    logic                   in_a = 1'b0;
    logic                   in_b = 1'b0;
    logic                   in_c = 1'b0;
    logic                   mt_sel, mt_a, mt_b, mt_c;
    logic                   mt_y;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   out_y;
    logic                   out_sel;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       done_cnt;

    always #5 clk = ~clk;

    // The tree itself: y = sel ? c : 1
    assign mt_y = mt_sel ? mt_c : 1'b1;

    mux_tree_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .mt_sel     (mt_sel),
        .mt_a       (mt_a),
        .mt_b       (mt_b),
        .mt_c       (mt_c),
        .mt_y       (mt_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_sel    (out_sel),
        .fifo_level (fifo_level),
        .done_cnt   (done_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] t);
        in_valid = v;
        {in_sel, in_a, in_b, in_c} = t;
    endtask

    typedef struct packed {
        logic sel;
        logic a;
        logic b;
        logic c;
    } txn_t;

    // Model: a queue of buffered operands plus one transaction "in the engine",
    // aged in cycles since it was loaded; it is visible downstream from age 1.
    txn_t m_q[$];
    txn_t m_cur = '0;
    bit   m_busy = 1'b0;
    int   m_age = 0;
    int   m_done = 0;
    logic m_y = 1'b0;
    logic m_sel_out = 1'b0;

    always @(posedge clk) begin
        bit   hs, pop, push;
        if (!rst_n) begin
            m_q.delete();
            m_cur     = '0;
            m_busy    = 1'b0;
            m_age     = 0;
            m_done    = 0;
            m_y       = 1'b0;
            m_sel_out = 1'b0;
        end else begin
            push = in_valid && (m_q.size() != DEPTH);
            hs   = m_busy && (m_age >= 1) && out_ready;
            pop  = (!m_busy || hs) && (m_q.size() > 0);
            if (hs) begin
                m_done++;
                m_busy = 1'b0;
            end
            if (pop) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_age  = 0;
            end else if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    m_y       = m_cur.sel ? m_cur.c : 1'b1;
                    m_sel_out = m_cur.sel;
                end
            end
            if (push) begin
                m_q.push_back({in_sel, in_a, in_b, in_c});
            end
        end
        #1;
        check("m_out_valid", out_valid, int'(m_busy && (m_age >= 1)));
        check("m_out_y", out_y, m_y);
        check("m_out_sel", out_sel, m_sel_out);
        check("m_fifo_level", fifo_level, m_q.size());
        check("m_in_ready", in_ready, int'(m_q.size() != DEPTH));
        check("m_done_cnt", done_cnt, m_done % (1 << CNT_W));
        check("m_mt", {mt_sel, mt_a, mt_b, mt_c}, m_cur);
    end

    logic [3:0] bp [8] = '{4'b1000, 4'b1001, 4'b0110, 4'b1100, 4'b1011,
                           4'b1111, 4'b1111, 4'b1111};
    int exp_y   [5] = '{0, 1, 1, 0, 1};
    int exp_sel [5] = '{1, 1, 0, 1, 1};

    initial begin
        int acc;
        int got_y[$];
        int got_sel[$];

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_mt", {mt_sel, mt_a, mt_b, mt_c}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transaction: push at edge k, pop at k+1, result valid after k+2
        out_ready = 1'b1;
        drive(1'b1, 4'b0100);
        @(negedge clk); drive(1'b0, 4'b0000);
        check("t1_level_after_push", fifo_level, 1);
        check("t1_valid_k", out_valid, 0);
        @(negedge clk);
        check("t1_mt_a", mt_a, 1);
        check("t1_level_after_pop", fifo_level, 0);
        check("t1_valid_k1", out_valid, 0);
        @(negedge clk);
        check("t1_valid_k2", out_valid, 1);
        check("t1_out_y", out_y, 1);
        check("t1_out_sel", out_sel, 0);
        @(negedge clk);
        check("t1_valid_k3", out_valid, 0);
        check("t1_done", done_cnt, 1);

        // Two back-to-back transactions: y=0 then y=1, two cycles apart
        drive(1'b1, 4'b1000);
        @(negedge clk); drive(1'b1, 4'b1001);
        @(negedge clk); drive(1'b0, 4'b0000);
        @(negedge clk);
        check("t2_valid_a", out_valid, 1);
        check("t2_y_a", out_y, 0);
        @(negedge clk);
        check("t2_gap", out_valid, 0);
        @(negedge clk);
        check("t2_valid_b", out_valid, 1);
        check("t2_y_b", out_y, 1);
        @(negedge clk);
        check("t2_gap_b", out_valid, 0);
        check("t2_done", done_cnt, 3);

        // Backpressure: DEPTH entries buffered plus one held on the tree
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, bp[acc]);
            if (in_ready) acc++;
            @(negedge clk);
        end
        check("t3_accepted", acc, 5);
        check("t3_level_full", fifo_level, 4);
        check("t3_in_ready", in_ready, 0);
        check("t3_out_valid", out_valid, 1);
        check("t3_out_y", out_y, 0);

        // Full FIFO with a pop this cycle still refuses the push
        out_ready = 1'b1;
        drive(1'b1, 4'b1111);
        if (out_valid) begin
            got_y.push_back(out_y);
            got_sel.push_back(out_sel);
        end
        @(negedge clk);
        check("t4_level_after_pop", fifo_level, 3);
        check("t4_in_ready_next", in_ready, 1);
        drive(1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                got_y.push_back(out_y);
                got_sel.push_back(out_sel);
            end
            @(negedge clk);
        end
        check("t3_result_count", got_y.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_y.size()) begin
                check($sformatf("t3_order_y%0d", i), got_y[i], exp_y[i]);
                check($sformatf("t3_order_sel%0d", i), got_sel[i], exp_sel[i]);
            end
        end
        check("t3_done", done_cnt, 0);

        // Counter wrap at CNT_W=2: five more results from a count of 0 leave 1
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0011);
            @(negedge clk); drive(1'b0, 4'b0000);
            repeat (3) @(negedge clk);
        end
        check("t6_wrap", done_cnt, 1);

        // Reset mid-operation: one transaction in HOLD, three queued
        out_ready = 1'b0;
        drive(1'b1, 4'b1111);
        @(negedge clk); drive(1'b1, 4'b0001);
        @(negedge clk); drive(1'b1, 4'b1010);
        @(negedge clk); drive(1'b1, 4'b0100);
        @(negedge clk); drive(1'b0, 4'b0000);
        @(negedge clk);
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_level", fifo_level, 3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_done", done_cnt, 0);
        check("t5_rst_mt", {mt_sel, mt_a, mt_b, mt_c}, 0);
        check("t5_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_replay_valid", out_valid, 0);
            check("t5_no_replay_level", fifo_level, 0);
        end

        // Random traffic with one asynchronous reset pulse in the middle
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, 4'($urandom));
            out_ready = ($urandom_range(0, 99) < 70);
            rst_n = (i != 200);
            @(negedge clk);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'b0000);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("rand_drained_level", fifo_level, 0);
        check("rand_drained_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_tree_sequencer.md
Name: mux_tree_sequencer

Overview:
Upstream issue stage for the combinational mux tree. It accepts operand transactions {sel, a, b, c} over a valid/ready handshake and buffers them in a small FIFO. It drives one transaction at a time onto the mux tree inputs from registers, captures the tree output y, and presents it downstream over a valid/ready handshake. The mux tree function is fixed: y = sel ? c : 1'b1. This holds because the tree's internal stage x1 = (x0<<2)+1 truncates to 1.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2
CNT_W, 8, width of completed-transaction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream operand valid
in_ready  out  1  FIFO can accept; equals !full
in_sel  in  1  operand sel
in_a  in  1  operand a
in_b  in  1  operand b
in_c  in  1  operand c
mt_sel  out  1  registered sel to mux tree
mt_a  out  1  registered a to mux tree
mt_b  out  1  registered b to mux tree
mt_c  out  1  registered c to mux tree
mt_y  in  1  mux tree output y
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  1  captured y
out_sel  out  1  sel of the transaction that produced out_y
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
done_cnt  out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty, fifo_level=0.
  - State goes to IDLE.
  - mt_*, out_y, out_sel, out_valid and done_cnt are all 0.
  - in_ready=1 (FIFO empty).
  - Any in-flight or buffered transaction is discarded; nothing is replayed after reset.
- Push: in_valid&&in_ready at an edge writes {in_sel,in_a,in_b,in_c} at the write pointer.
- No bypass: when full, in_ready=0 even if a pop occurs in the same cycle. When empty, a pushed entry is not visible to the FSM until the next cycle.
- Pop: occurs only as described by the FSM. It loads the head entry into mt_sel/mt_a/mt_b/mt_c. mt_* hold their value until the next pop.
- fifo_level is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE: if fifo_level!=0, pop and go to ISSUE; else stay.
  - ISSUE: mt_* are stable this whole cycle. At the edge, out_y<=mt_y, out_sel<=mt_sel, out_valid<=1, go to HOLD.
  - HOLD: out_valid=1; out_y and out_sel are held stable.
    - If out_ready=0: stay.
    - If out_ready=1: done_cnt+=1 and out_valid<=0. Then if fifo_level!=0, pop and go to ISSUE; else go to IDLE.
- Latency:
  - Push at edge k into an empty FIFO with FSM in IDLE → pop at edge k+1 → out_valid high after edge k+2.
- Throughput: with out_ready held at 1, one result every 2 cycles; out_valid alternates 1,0.
- Capacity: while HOLD stalls, DEPTH entries are buffered plus one in the mt_* registers.
- done_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- out_valid must not drop without a handshake. out_y and out_sel must not change while out_valid=1 && out_ready=0.

Test Plan:
- Single transaction, sel=0, a=1, b=0, c=0, out_ready=1:
  - Expect out_y=1, out_sel=0.
  - Expect out_valid high for exactly 1 cycle, rising 2 edges after the accepting edge.
  - Expect done_cnt=1.
- Two transactions (sel=1,c=0) then (sel=1,c=1), out_ready=1:
  - Expect out_y=0 then 1, each in its own valid cycle, 2 cycles apart.
  - Expect done_cnt=2.
- Backpressure, DEPTH=4, out_ready=0, in_valid held high:
  - Expect exactly 5 transactions accepted, then fifo_level=4 and in_ready=0.
  - Expect out_valid=1 with out_y stable.
  - Raise out_ready: expect 5 results in push order, with fifo_level decrementing on each pop.
- Full FIFO with out_ready=1 and in_valid=1:
  - Expect no push on the pop cycle (in_ready=0).
  - Expect in_ready=1 on the following cycle.
- Reset mid-operation: assert rst_n=0 during HOLD with 3 entries queued.
  - Expect immediately out_valid=0, fifo_level=0, done_cnt=0, mt_*=0.
  - After release, expect no output until new pushes arrive.
- Counter wrap, CNT_W=2: complete 5 transactions → expect done_cnt=1.
